moving_avg_decim: RTL and testbench

- Boxcar moving-average filter on the 12-bit ADC sample stream, in the fast_clk domain.
- Sits directly upstream of the fast-to-slow domain-crossing stage and produces the smoothed data word that stage samples.
- Averages the last 2^LOG2_N accepted samples using a running sum and a ring-buffer delay line.
- Emits one filtered sample per accepted input.

---
 rtl/dsp_pkg.sv | 19 +
 rtl/sample_ring.sv | 44 ++++
 rtl/moving_avg_decim.sv | 81 ++++++++
 tb/tb_moving_avg_decim.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsp_pkg
// Purpose  : Shared DSP types and helpers for the ADC sample path.
// Revision : 1.0 - initial release
// ============================================================================
package dsp_pkg;

    localparam int SAMPLE_W = 12;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Width of an accumulator holding 2^log2n full-scale samples without overflow
    function automatic int sum_width(input int log2n);
        return SAMPLE_W + log2n;
    endfunction

endpackage : dsp_pkg
`default_nettype wire

// File: rtl/sample_ring.sv
`default_nettype none
// ============================================================================
// Module   : sample_ring
// Purpose  : 2^LOG2_N entry delay line with a wrapping write pointer. The
//            entry at the write pointer (the oldest sample, about to be
//            overwritten) is presented combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module sample_ring
    import dsp_pkg::*;
#(
    parameter int WIDTH  = SAMPLE_W,
    parameter int LOG2_N = 3
) (
    input  logic             fast_clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] oldest
);

    localparam int DEPTH = 1 << LOG2_N;

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [LOG2_N-1:0] r_wp;

    // The slot about to be overwritten holds the sample leaving the window
    assign oldest = r_mem[r_wp];

    // Write the new sample over the oldest one; pointer wraps naturally at 2^LOG2_N
    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            r_wp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[r_wp] <= wr_data;
            r_wp        <= r_wp + 1'b1;
        end
    end

endmodule : sample_ring
`default_nettype wire

// File: rtl/moving_avg_decim.sv
`default_nettype none
// ============================================================================
// Module   : moving_avg_decim
// Purpose  : Boxcar moving average over the last 2^LOG2_N accepted ADC
//            samples using a running sum and a ring-buffer delay line.
//            One registered output per accepted input.
// Options  : MOVING_AVG_ROUND_EN - round half-up instead of truncating.
// Revision : 1.0 - initial release
// ============================================================================
module moving_avg_decim
    import dsp_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int LOG2_N = 3
) (
    input  logic              fast_clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              primed
);

    // Accumulator sized so N full-scale samples fit exactly
    localparam int SUM_W  = sum_width(LOG2_N) + DATA_W - SAMPLE_W;
    localparam int FILL_W = LOG2_N + 1;

    logic [SUM_W-1:0]  r_sum;
    logic [FILL_W-1:0] r_fill;
    logic [DATA_W-1:0] w_oldest;
    logic [SUM_W-1:0]  w_sum_next;
    logic [DATA_W-1:0] w_avg;

    sample_ring #(
        .WIDTH  (DATA_W),
        .LOG2_N (LOG2_N)
    ) u_ring (
        .fast_clk (fast_clk),
        .reset    (reset),
        .wr_en    (in_valid),
        .wr_data  (in_data),
        .oldest   (w_oldest)
    );

    // Slide the window: add the newcomer, drop the evicted sample (never underflows)
    assign w_sum_next = r_sum + SUM_W'(in_data) - SUM_W'(w_oldest);

    // Divide by N; the rounding variant adds the bit just below the cut,
    // which equals adding N/2 before the shift and cannot overflow
    always_comb begin
        w_avg = w_sum_next[LOG2_N +: DATA_W];
`ifdef MOVING_AVG_ROUND_EN
        w_avg = w_sum_next[LOG2_N +: DATA_W] + DATA_W'(w_sum_next[LOG2_N-1]);
`endif
    end

    // Accumulator, fill counter and registered outputs, all advancing on accept
    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            r_sum     <= '0;
            r_fill    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                r_sum    <= w_sum_next;
                out_data <= w_avg;
                if (!r_fill[LOG2_N]) begin
                    r_fill <= r_fill + 1'b1;
                end
            end
        end
    end

    // Fill counter saturates at exactly N, which is its MSB alone
    assign primed = r_fill[LOG2_N];

endmodule : moving_avg_decim
`default_nettype wire

// File: tb/tb_moving_avg_decim.sv
`default_nettype none
// ============================================================================
// Module   : tb_moving_avg_decim
// Purpose  : Scoreboard bench for moving_avg_decim (DATA_W=12, LOG2_N=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_moving_avg_decim;

    logic        fast_clk = 1'b0;
    logic        reset    = 1'b1;
    logic        in_valid = 1'b0;
    logic [11:0] in_data  = '0;
    logic        out_valid;
    logic [11:0] out_data;
    logic        primed;

    int checks = 0;
    int passes = 0;
    logic [11:0] exp_q [$];

    moving_avg_decim #(.DATA_W(12), .LOG2_N(3)) dut (
        .fast_clk  (fast_clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .primed    (primed)
    );

    always #5 fast_clk = ~fast_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // One cycle of stimulus; an accept queues its hand-computed expected output
    task automatic drive(input logic v, input logic [11:0] d, input logic [11:0] e);
        in_valid = v;
        in_data  = d;
        if (v) exp_q.push_back(e);
        @(posedge fast_clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Asynchronous reset pulse, checked before any clock edge can intervene
    task automatic async_reset_check(input string name);
        reset = 1'b1;
        #2;
        chk({name, "_out_data"},  {20'd0, out_data}, 32'h0);
        chk({name, "_out_valid"}, {31'd0, out_valid}, 32'h0);
        chk({name, "_primed"},    {31'd0, primed}, 32'h0);
        @(posedge fast_clk);
        #1;
        reset = 1'b0;
    endtask

    // Saturating ramp from a 0x800-filled window toward 0xFFF
    function automatic logic [11:0] fff_exp(input int k);
`ifdef MOVING_AVG_ROUND_EN
        case (k)
            0: return 12'h900;
            1: return 12'hA00;
            2: return 12'hB00;
            3: return 12'hC00;
            4: return 12'hCFF;
            5: return 12'hDFF;
            6: return 12'hEFF;
            default: return 12'hFFF;
        endcase
`else
        case (k)
            0: return 12'h8FF;
            1: return 12'h9FF;
            2: return 12'hAFF;
            3: return 12'hBFF;
            4: return 12'hCFF;
            5: return 12'hDFF;
            6: return 12'hEFF;
            default: return 12'hFFF;
        endcase
`endif
    endfunction

    // Alternating 0x000/0xFFF entering a window full of 0xFFF
    function automatic logic [11:0] alt_exp(input int k);
        if (k < 2) return 12'hDFF;
        if (k < 4) return 12'hBFF;
        if (k < 6) return 12'h9FF;
`ifdef MOVING_AVG_ROUND_EN
        return 12'h800;
`else
        return 12'h7FF;
`endif
    endfunction

    // Monitor: every output pulse must match the oldest pending expectation
    always @(negedge fast_clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                chk("out_data", {20'd0, out_data}, {20'd0, e});
            end
        end
    end

    initial begin
        logic [11:0] held;

        repeat (3) @(posedge fast_clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
        chk("rst_out_data",  {20'd0, out_data}, 32'h0);
        chk("rst_primed",    {31'd0, primed}, 32'h0);
        reset = 1'b0;

        // Warm-up ramp: 8 x 0x800 -> 0x100 .. 0x800, primed after the 8th
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 12'h800, 12'(k * 12'h100));
            if (k == 7) chk("primed_after_7", {31'd0, primed}, 32'h0);
        end
        chk("primed_after_8", {31'd0, primed}, 32'h1);

        // Full scale: no overflow, settles and holds at 0xFFF
        for (int k = 0; k < 16; k++) drive(1'b1, 12'hFFF, fff_exp(k));

        // Alternating extremes from a 0xFFF window
        for (int k = 0; k < 12; k++) drive(1'b1, (k % 2 == 0) ? 12'h000 : 12'hFFF, alt_exp(k));
        drive(1'b0, 12'h000, 12'h000);
        chk("primed_holds", {31'd0, primed}, 32'h1);
        async_reset_check("rst_primed_stream");

        // Gapped valids: 1,0,0 pattern carrying 0x010
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 12'h010, 12'(2 * k));
            held = 12'(2 * k);
            for (int g = 0; g < 2; g++) begin
                drive(1'b0, 12'hABC, 12'h000);
                chk("gap_out_valid", {31'd0, out_valid}, 32'h0);
                chk("gap_hold",      {20'd0, out_data}, {20'd0, held});
            end
        end
        chk("gap_not_primed", {31'd0, primed}, 32'h0);
        async_reset_check("rst_gap");

        // Mid-stream reset after 5 x 0x400
        for (int k = 1; k <= 5; k++) drive(1'b1, 12'h400, 12'(k * 12'h080));
        drive(1'b0, 12'h000, 12'h000);
        async_reset_check("rst_mid");
        drive(1'b1, 12'h400, 12'h080);

        // Step: prime at zero (the lone 0x400 drains out on the 8th), then 0x800
        for (int k = 1; k <= 8; k++) drive(1'b1, 12'h000, (k < 8) ? 12'h080 : 12'h000);
        chk("step_primed", {31'd0, primed}, 32'h1);
        for (int k = 1; k <= 8; k++) drive(1'b1, 12'h800, 12'(k * 12'h100));
        chk("step_reach_800", {20'd0, out_data}, 32'h800);
        drive(1'b1, 12'h800, 12'h800);
        drive(1'b0, 12'h000, 12'h000);
        drive(1'b0, 12'h000, 12'h000);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_moving_avg_decim
`default_nettype wire
